beat_detector: RTL and testbench

- Analysis front end for the drum-roll path. It watches the incoming stereo audio, detects percussive onsets from block energy, and produces the single-cycle `transient` pulse and the beat-interval `bpm` word that the transient generator consumes.
- `bpm` is in decimated units: one unit is 2^DECIMATION_BITS samples.
- It sits in parallel with the audio path and does not modify the audio.

---
 rtl/beat_pkg.sv | 24 ++
 rtl/block_energy.sv | 84 ++++++++
 rtl/beat_detector.sv | 157 +++++++++++++++
 tb/tb_beat_detector.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : beat_pkg                                                    |
// | Purpose  : Shared types and constants for the drum-roll analysis path. |
// |            The transient generator imports the same constants so that  |
// |            both sides agree on the units of the bpm word.              |
// | Contents : beat_state_t (WARMUP, ARMED, HOLDOFF), DATA_IN_BITS,        |
// |            DECIMATION_BITS, BPM_BITS.                                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package beat_pkg;

   localparam int DATA_IN_BITS    = 24;
   localparam int DECIMATION_BITS = 6;
   localparam int BPM_BITS        = 11;

   typedef enum logic [1:0] {
      WARMUP  = 2'd0,
      ARMED   = 2'd1,
      HOLDOFF = 2'd2
   } beat_state_t;

endpackage
`default_nettype wire

// File: rtl/block_energy.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : block_energy                                                |
// | Purpose  : Rectifies stereo samples (|l| + |r|) and sums them over     |
// |            blocks of 2^DECIMATION_BITS valid samples.                  |
// | Ports    : clk, rst          - clock, synchronous active-high reset    |
// |            sample_valid      - qualifies data_in_l / data_in_r         |
// |            data_in_l/_r      - signed samples                          |
// |            e, e_valid        - block energy and its one-cycle strobe   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module block_energy #(
   parameter int DATA_IN_BITS    = 24,
   parameter int DECIMATION_BITS = 6
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    sample_valid,
   input  logic [DATA_IN_BITS-1:0]                 data_in_l,
   input  logic [DATA_IN_BITS-1:0]                 data_in_r,
   output logic [DATA_IN_BITS+DECIMATION_BITS-1:0] e,
   output logic                                    e_valid
);

   localparam int ACC_W = DATA_IN_BITS + DECIMATION_BITS;
   localparam int MAG_W = DATA_IN_BITS - 1;

   logic [MAG_W-1:0]           w_neg_l, w_neg_r;
   logic [MAG_W-1:0]           w_abs_l, w_abs_r;
   logic [DATA_IN_BITS-1:0]    w_mag;
   logic [ACC_W-1:0]           w_acc_sum;
   logic [ACC_W-1:0]           r_acc;
   logic [DECIMATION_BITS-1:0] r_cnt;

   // Only the low MAG_W bits of the negation are needed: the magnitude of
   // any code except the most-negative one fits there. The most-negative
   // code would come out as 0, so it is saturated to all-ones explicitly.
   always_comb begin
      w_neg_l = MAG_W'(~data_in_l[MAG_W-1:0]) + MAG_W'(1);
      w_neg_r = MAG_W'(~data_in_r[MAG_W-1:0]) + MAG_W'(1);

      if (!data_in_l[DATA_IN_BITS-1])
         w_abs_l = data_in_l[MAG_W-1:0];
      else if (~|data_in_l[MAG_W-1:0])
         w_abs_l = '1;
      else
         w_abs_l = w_neg_l;

      if (!data_in_r[DATA_IN_BITS-1])
         w_abs_r = data_in_r[MAG_W-1:0];
      else if (~|data_in_r[MAG_W-1:0])
         w_abs_r = '1;
      else
         w_abs_r = w_neg_r;

      // Two MAG_W-bit magnitudes always fit in DATA_IN_BITS bits.
      w_mag     = {1'b0, w_abs_l} + {1'b0, w_abs_r};
      w_acc_sum = r_acc + ACC_W'(w_mag);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         e       <= '0;
         e_valid <= 1'b0;
      end else begin
         e_valid <= 1'b0;
         if (sample_valid) begin
            r_cnt <= r_cnt + DECIMATION_BITS'(1);
            if (&r_cnt) begin
               // Last sample of the block: publish the full sum and start over.
               e       <= w_acc_sum;
               e_valid <= 1'b1;
               r_acc   <= '0;
            end else begin
               r_acc <= w_acc_sum;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/beat_detector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : beat_detector                                               |
// | Purpose  : Detects percussive onsets from block energy compared with a |
// |            running average, and measures the interval between onsets. |
// | Ports    : clk, rst          - clock, synchronous active-high reset    |
// |            sample_valid      - qualifies data_in_l / data_in_r         |
// |            data_in_l/_r      - signed stereo samples                   |
// |            transient         - one-cycle onset pulse                   |
// |            bpm               - last accepted interval, in blocks       |
// |            bpm_valid         - one-cycle pulse when bpm updates        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module beat_detector
   import beat_pkg::*;
#(
   parameter int DATA_IN_BITS    = beat_pkg::DATA_IN_BITS,
   parameter int DECIMATION_BITS = beat_pkg::DECIMATION_BITS,
   parameter int BPM_BITS        = beat_pkg::BPM_BITS,
   parameter int SMOOTH_SHIFT    = 4,
   parameter int THRESH_X8       = 12,
   parameter int ENERGY_FLOOR    = 2**20,
   parameter int MIN_BLOCKS      = 4,
   parameter int WARMUP_BLOCKS   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_valid,
   input  logic [DATA_IN_BITS-1:0] data_in_l,
   input  logic [DATA_IN_BITS-1:0] data_in_r,
   output logic                    transient,
   output logic [BPM_BITS-1:0]     bpm,
   output logic                    bpm_valid
);

   localparam int ACC_W   = DATA_IN_BITS + DECIMATION_BITS;
   localparam int PROD_W  = ACC_W + 4;
   localparam int CNT_MAX = (WARMUP_BLOCKS > MIN_BLOCKS) ? WARMUP_BLOCKS : MIN_BLOCKS;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   logic [ACC_W-1:0]        w_e;
   logic                    w_e_valid;

   logic [PROD_W-1:0]       w_e_x8, w_avg_xt;
   logic                    w_onset;
   logic signed [ACC_W:0]   w_diff, w_avg_sum;
   logic [ACC_W-1:0]        w_avg_next;
   logic                    w_since_sat;
   logic [BPM_BITS-1:0]     w_measured, w_since_inc;
   logic                    w_accept;

   beat_state_t             r_state;
   logic [CNT_W-1:0]        r_blk_cnt;
   logic [ACC_W-1:0]        r_avg;
   logic [BPM_BITS-1:0]     r_since;
   logic                    r_have_prev;

   block_energy #(
      .DATA_IN_BITS    (DATA_IN_BITS),
      .DECIMATION_BITS (DECIMATION_BITS)
   ) u_energy (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .data_in_l    (data_in_l),
      .data_in_r    (data_in_r),
      .e            (w_e),
      .e_valid      (w_e_valid)
   );

   always_comb begin
      // Ratio test e > avg * THRESH_X8/8 done without division; the 4 extra
      // bits cover both the x8 and the x12 product.
      w_e_x8   = {1'b0, w_e, 3'b000};
      w_avg_xt = PROD_W'(r_avg) * PROD_W'(THRESH_X8);
      w_onset  = (w_e_x8 > w_avg_xt) && (w_e >= ACC_W'(ENERGY_FLOOR)) &&
                 (r_state == ARMED);

      // avg + ((e - avg) >>> SHIFT) lies in [-1, max(e, avg)], so one extra
      // sign bit is enough and only the negative side needs clamping.
      w_diff     = $signed({1'b0, w_e}) - $signed({1'b0, r_avg});
      w_avg_sum  = $signed({1'b0, r_avg}) + (w_diff >>> SMOOTH_SHIFT);
      w_avg_next = w_avg_sum[ACC_W] ? '0 : w_avg_sum[ACC_W-1:0];

      w_since_sat = &r_since;
      w_measured  = r_since + BPM_BITS'(1);
      w_since_inc = w_since_sat ? r_since : w_measured;
      w_accept    = w_onset && r_have_prev && !w_since_sat &&
                    (w_measured >= BPM_BITS'(MIN_BLOCKS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= WARMUP;
         r_blk_cnt   <= '0;
         r_avg       <= '0;
         r_since     <= '0;
         r_have_prev <= 1'b0;
         transient   <= 1'b0;
         bpm         <= '0;
         bpm_valid   <= 1'b0;
      end else begin
         transient <= 1'b0;
         bpm_valid <= 1'b0;

         if (w_e_valid) begin
            r_avg <= w_avg_next;

            if (w_onset) begin
               transient   <= 1'b1;
               r_since     <= '0;
               r_have_prev <= 1'b1;
               if (w_accept) begin
                  bpm       <= w_measured;
                  bpm_valid <= 1'b1;
               end
            end else begin
               r_since <= w_since_inc;
               // A saturated interval is no longer a valid reference.
               if (&w_since_inc)
                  r_have_prev <= 1'b0;
            end

            case (r_state)
               WARMUP: begin
                  if (r_blk_cnt == CNT_W'(WARMUP_BLOCKS - 1)) begin
                     r_state   <= ARMED;
                     r_blk_cnt <= '0;
                  end else begin
                     r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                  end
               end
               ARMED: begin
                  if (w_onset) begin
                     r_state   <= HOLDOFF;
                     r_blk_cnt <= '0;
                  end
               end
               HOLDOFF: begin
                  if (r_blk_cnt == CNT_W'(MIN_BLOCKS - 1)) begin
                     r_state   <= ARMED;
                     r_blk_cnt <= '0;
                  end else begin
                     r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  r_state   <= WARMUP;
                  r_blk_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_beat_detector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_beat_detector                                            |
// | Purpose  : Directed self-checking bench for beat_detector. BPM_BITS is |
// |            reduced to 8 so the interval counter saturates after 255    |
// |            blocks and the timeout scenario stays short.                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_beat_detector;

   localparam int BB  = 8;
   localparam int SPB = 64;

   localparam logic [23:0] ZERO = 24'h000000;
   localparam logic [23:0] BG_P = 24'h001000;
   localparam logic [23:0] BG_N = 24'hFFF000;
   localparam logic [23:0] BU_P = 24'h400000;
   localparam logic [23:0] BU_N = 24'hC00000;
   localparam logic [23:0] MNEG = 24'h800000;

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_valid;
   logic [23:0]   data_in_l, data_in_r;
   logic          transient;
   logic [BB-1:0] bpm;
   logic          bpm_valid;

   int            checks = 0;
   int            errors = 0;
   logic [BB-1:0] cur_bpm;

   beat_detector #(
      .BPM_BITS (BB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .data_in_l    (data_in_l),
      .data_in_r    (data_in_r),
      .transient    (transient),
      .bpm          (bpm),
      .bpm_valid    (bpm_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: present inputs, take the edge, settle 1 time unit past it.
   task automatic cyc(input logic v, input logic [23:0] l, input logic [23:0] r);
      sample_valid = v;
      data_in_l    = l;
      data_in_r    = r;
      @(posedge clk);
      #1;
   endtask

   // One full block followed by idle cycles; checks the two-cycle latency
   // window counted from the final valid sample.
   task automatic blk(input logic [23:0] l, input logic [23:0] r, input bit alt,
                      input bit exp_tr, input bit exp_bv, input string tag);
      for (int i = 0; i < SPB; i++) begin
         cyc(1'b1, l, r);
         if (alt && i != SPB - 1) cyc(1'b0, ZERO, ZERO);
      end
      chk({tag, " transient@+1"}, 32'(transient), 32'(1'b0));
      chk({tag, " bpm_valid@+1"}, 32'(bpm_valid), 32'(1'b0));
      cyc(1'b0, ZERO, ZERO);
      if (exp_bv) cur_bpm = BB'(20);
      chk({tag, " transient@+2"}, 32'(transient), 32'(exp_tr));
      chk({tag, " bpm_valid@+2"}, 32'(bpm_valid), 32'(exp_bv));
      chk({tag, " bpm@+2"},       32'(bpm),       32'(cur_bpm));
      cyc(1'b0, ZERO, ZERO);
      chk({tag, " transient@+3"}, 32'(transient), 32'(1'b0));
   endtask

   task automatic bg(input int n, input bit alt, input string tag);
      for (int i = 0; i < n; i++) blk(BG_P, BG_N, alt, 1'b0, 1'b0, tag);
   endtask

   initial begin
      cur_bpm = '0;
      rst     = 1'b1;
      cyc(1'b0, ZERO, ZERO);
      cyc(1'b0, ZERO, ZERO);
      chk("reset transient", 32'(transient), 32'(1'b0));
      chk("reset bpm",       32'(bpm),       32'(0));
      chk("reset bpm_valid", 32'(bpm_valid), 32'(1'b0));
      rst = 1'b0;

      // Silence: no detections at all.
      for (int i = 0; i < 200; i++) blk(ZERO, ZERO, 1'b0, 1'b0, 1'b0, "silence");

      // Periodic bursts every 20 blocks.
      bg(19, 1'b0, "bg");
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b0, "burst first");
      bg(19, 1'b0, "bg");
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b1, "burst second");
      bg(19, 1'b0, "bg");
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b1, "burst third");

      // Holdoff: back-to-back bursts give one transient.
      bg(19, 1'b0, "bg");
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b1, "holdoff first");
      blk(BU_P, BU_N, 1'b0, 1'b0, 1'b0, "holdoff second");
      bg(18, 1'b0, "bg");
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b1, "after holdoff");

      // Timeout: the interval counter saturates, so the next onset is not
      // a measurement and bpm holds.
      bg(260, 1'b0, "bg long");
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b0, "after timeout");
      bg(19, 1'b0, "bg");
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b1, "timeout resumed");

      // Negative bursts with gaps, then the most-negative code.
      bg(19, 1'b1, "bg gaps");
      blk(BU_N, BU_N, 1'b1, 1'b1, 1'b1, "negative gapped");
      bg(19, 1'b0, "bg");
      blk(MNEG, MNEG, 1'b0, 1'b1, 1'b1, "most negative");

      // Reset in the middle of a burst block.
      bg(19, 1'b0, "bg");
      for (int i = 0; i < 30; i++) cyc(1'b1, BU_P, BU_N);
      rst = 1'b1;
      cyc(1'b1, BU_P, BU_N);
      rst = 1'b0;
      chk("midreset transient", 32'(transient), 32'(1'b0));
      chk("midreset bpm",       32'(bpm),       32'(0));
      chk("midreset bpm_valid", 32'(bpm_valid), 32'(1'b0));
      cur_bpm = '0;
      for (int i = 0; i < 16; i++) begin
         if (i == 0 || i == 7 || i == 15)
            blk(BU_P, BU_N, 1'b0, 1'b0, 1'b0, "warmup burst");
         else
            blk(BG_P, BG_N, 1'b0, 1'b0, 1'b0, "warmup bg");
      end
      blk(BU_P, BU_N, 1'b0, 1'b1, 1'b0, "first armed");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
